// File: rtl/frog_input_ctrl.sv
// Frogger input/life-cycle controller: debounced switches -> grid-stepped position, plus hop/die/respawn/win/over FSM.
// Define FROG_AUTOREPEAT_EN to let a held direction re-hop each time the hop cooldown expires.

module frog_input_ctrl_deb #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic stable,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta, sync, stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      meta     <= raw;
      sync     <= meta;
      stable_q <= stable;
      if (sync == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end

  assign press = stable & ~stable_q;
endmodule

module frog_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOP_COOLDOWN    = 2500000,
  parameter int STEP            = 32,
  parameter int H_DISPLAY       = 640,
  parameter int V_DISPLAY       = 480,
  parameter int PLAYER_WIDTH    = 32,
  parameter int PLAYER_HEIGHT   = 32,
  parameter int START_X         = 304,
  parameter int START_Y         = 416,
  parameter int DEAD_FRAMES     = 60,
  parameter int LIVES_INIT      = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       collision,
  input  logic       frame_tick,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       hop_pulse,
  output logic       win_pulse,
  output logic [1:0] lives,
  output logic       dead,
  output logic       game_over
);
  localparam int CDW = $clog2(HOP_COOLDOWN + 1);
  localparam int FCW = $clog2(DEAD_FRAMES + 1);

  typedef enum logic [1:0] {PLAY, COOLDOWN, DEAD, OVER} state_t;

  state_t         state_q, state_d;
  logic [9:0]     x_d, y_d;
  logic [1:0]     lives_d;
  logic           hop_d, win_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [FCW-1:0] fc_q, fc_d;

  // bit order: [0]=up, [1]=down, [2]=left, [3]=right
  logic [3:0] raw_sw, lvl, prs, evt;
  assign raw_sw = {SW4, SW3, SW2, SW1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    frog_input_ctrl_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .CLK(CLK), .RST_N(RST_N), .raw(raw_sw[i]), .stable(lvl[i]), .press(prs[i])
    );
  end

  logic rpt_q;
`ifdef FROG_AUTOREPEAT_EN
  // Armed for the single PLAY cycle that follows cooldown expiry.
  always_ff @(posedge CLK) begin
    if (!RST_N) rpt_q <= 1'b0;
    else        rpt_q <= (state_q == COOLDOWN) && (state_d == PLAY) && !win_d;
  end
`else
  assign rpt_q = 1'b0;
`endif
  assign evt = prs | (rpt_q ? lvl : 4'b0000);

  // 11-bit bounds arithmetic so the sums cannot wrap
  logic [10:0] x11, y11;
  logic        ok_up, ok_dn, ok_lt, ok_rt;
  assign x11   = {1'b0, player_x};
  assign y11   = {1'b0, player_y};
  assign ok_up = y11 >= 11'(STEP);
  assign ok_dn = (y11 + 11'(PLAYER_HEIGHT) + 11'(STEP)) <= 11'(V_DISPLAY);
  assign ok_lt = x11 >= 11'(STEP);
  assign ok_rt = (x11 + 11'(PLAYER_WIDTH) + 11'(STEP)) <= 11'(H_DISPLAY);

  always_comb begin
    state_d = state_q;
    x_d     = player_x;
    y_d     = player_y;
    lives_d = lives;
    hop_d   = 1'b0;
    win_d   = 1'b0;
    cd_d    = cd_q;
    fc_d    = fc_q;
    case (state_q)
      PLAY, COOLDOWN: begin
        if (collision) begin
          cd_d = '0;
          fc_d = '0;
          if (lives > 2'd1) begin
            lives_d = lives - 2'd1;
            state_d = DEAD;
          end else begin
            lives_d = 2'd0;
            state_d = OVER;
          end
        end else if (player_y == 10'd0) begin
          win_d   = 1'b1;
          x_d     = 10'(START_X);
          y_d     = 10'(START_Y);
          cd_d    = '0;
          state_d = PLAY;
        end else if (state_q == COOLDOWN) begin
          if (cd_q == CDW'(HOP_COOLDOWN - 1)) begin
            cd_d    = '0;
            state_d = PLAY;
          end else cd_d = cd_q + 1'b1;
        end else begin
          // only the highest-priority event is considered; the rest are dropped
          if (evt[0]) begin
            if (ok_up) begin y_d = player_y - 10'(STEP); hop_d = 1'b1; end
          end else if (evt[1]) begin
            if (ok_dn) begin y_d = player_y + 10'(STEP); hop_d = 1'b1; end
          end else if (evt[2]) begin
            if (ok_lt) begin x_d = player_x - 10'(STEP); hop_d = 1'b1; end
          end else if (evt[3]) begin
            if (ok_rt) begin x_d = player_x + 10'(STEP); hop_d = 1'b1; end
          end
          if (hop_d) begin
            cd_d    = '0;
            state_d = COOLDOWN;
          end
        end
      end
      DEAD: begin
        if (frame_tick) begin
          if (fc_q == FCW'(DEAD_FRAMES - 1)) begin
            fc_d    = '0;
            x_d     = 10'(START_X);
            y_d     = 10'(START_Y);
            state_d = PLAY;
          end else fc_d = fc_q + 1'b1;
        end
      end
      OVER: begin
        if (|evt) begin
          lives_d = 2'(LIVES_INIT);
          x_d     = 10'(START_X);
          y_d     = 10'(START_Y);
          state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= PLAY;
      player_x  <= 10'(START_X);
      player_y  <= 10'(START_Y);
      lives     <= 2'(LIVES_INIT);
      hop_pulse <= 1'b0;
      win_pulse <= 1'b0;
      cd_q      <= '0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      player_x  <= x_d;
      player_y  <= y_d;
      lives     <= lives_d;
      hop_pulse <= hop_d;
      win_pulse <= win_d;
      cd_q      <= cd_d;
      fc_q      <= fc_d;
    end
  end

  assign dead      = (state_q == DEAD);
  assign game_over = (state_q == OVER);
endmodule

// File: tb/tb_frog_input_ctrl.sv
// Directed bench for frog_input_ctrl with short debounce/cooldown so every scenario runs in a few hundred cycles.
module tb_frog_input_ctrl;
  localparam int D  = 4;
  localparam int HC = 10;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic       collision = 1'b0, frame_tick = 1'b0;
  logic [9:0] player_x, player_y;
  logic       hop_pulse, win_pulse, dead, game_over;
  logic [1:0] lives;
  int errs = 0, checks = 0;

  always #5 CLK = ~CLK;

  frog_input_ctrl #(.DEBOUNCE_CYCLES(D), .HOP_COOLDOWN(HC)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW1(sw[0]), .SW2(sw[1]), .SW3(sw[2]), .SW4(sw[3]),
    .collision(collision), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y), .hop_pulse(hop_pulse), .win_pulse(win_pulse),
    .lives(lives), .dead(dead), .game_over(game_over)
  );

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset();
    RST_N = 1'b0; sw = 4'b0; collision = 1'b0; frame_tick = 1'b0;
    step(2);
    RST_N = 1'b1;
  endtask

  // press pattern m long enough to debounce, release, and wait out cooldown
  task automatic tap(input logic [3:0] m, output int nh, output int nw);
    nh = 0; nw = 0; sw = m;
    for (int i = 0; i < D + 4; i++) begin step(1); nh += int'(hop_pulse); nw += int'(win_pulse); end
    sw = 4'b0;
    for (int i = 0; i < 2*D + HC + 8; i++) begin step(1); nh += int'(hop_pulse); nw += int'(win_pulse); end
  endtask

  task automatic tick(input int n);
    repeat (n) begin frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(2); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (player_x !== 10'd304) begin errs++; $display("FAIL reset_x got=%0d exp=304", player_x); end
    checks++; if (player_y !== 10'd416) begin errs++; $display("FAIL reset_y got=%0d exp=416", player_y); end
    checks++; if (lives !== 2'd3) begin errs++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    checks++; if ({hop_pulse, win_pulse, dead, game_over} !== 4'b0) begin
      errs++; $display("FAIL reset_flags got=%b exp=0000", {hop_pulse, win_pulse, dead, game_over}); end
  endtask

  task automatic test_hop_latency();
    int nh;
    sw = 4'b0001;
    step(D + 2);
    checks++; if (hop_pulse !== 1'b0) begin errs++; $display("FAIL hop_early got=%b exp=0", hop_pulse); end
    step(1);
    checks++; if (hop_pulse !== 1'b1) begin errs++; $display("FAIL hop_latency got=%b exp=1", hop_pulse); end
    checks++; if (player_y !== 10'd384) begin errs++; $display("FAIL hop_y got=%0d exp=384", player_y); end
    step(1);
    checks++; if (hop_pulse !== 1'b0) begin errs++; $display("FAIL hop_width got=%b exp=0", hop_pulse); end
    step(1);
    sw = 4'b0; nh = 0;
    for (int i = 0; i < 2*D + HC + 8; i++) begin step(1); nh += int'(hop_pulse); end
    checks++; if (nh != 0) begin errs++; $display("FAIL hop_held_once got=%0d exp=0", nh); end
  endtask

  task automatic test_glitch();
    int nh = 0;
    sw = 4'b0010;
    step(D - 1);
    sw = 4'b0;
    for (int i = 0; i < 3*D + 10; i++) begin step(1); nh += int'(hop_pulse); end
    checks++; if (nh != 0) begin errs++; $display("FAIL glitch_hops got=%0d exp=0", nh); end
    checks++; if (player_y !== 10'd384) begin errs++; $display("FAIL glitch_y got=%0d exp=384", player_y); end
  endtask

  task automatic test_bounds();
    int nh, nw, tot = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin tap(4'b0100, nh, nw); tot += nh; end
    checks++; if (tot != 9 || player_x !== 10'd16) begin
      errs++; $display("FAIL left_walk got=%0d/%0d exp=9/16", tot, player_x); end
    tap(4'b0100, nh, nw);
    checks++; if (nh != 0 || player_x !== 10'd16) begin
      errs++; $display("FAIL left_edge got=%0d/%0d exp=0/16", nh, player_x); end
    tap(4'b1001, nh, nw);
    checks++; if (nh != 1 || player_x !== 10'd16 || player_y !== 10'd384) begin
      errs++; $display("FAIL up_over_right got=%0d/%0d/%0d exp=1/16/384", nh, player_x, player_y); end
    tap(4'b0010, nh, nw);
    tap(4'b0010, nh, nw);
    checks++; if (nh != 1 || player_y !== 10'd448) begin
      errs++; $display("FAIL down_last got=%0d/%0d exp=1/448", nh, player_y); end
    tap(4'b0010, nh, nw);
    checks++; if (nh != 0 || player_y !== 10'd448) begin
      errs++; $display("FAIL down_edge got=%0d/%0d exp=0/448", nh, player_y); end
  endtask

  task automatic test_back_to_back();
    int nh = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      sw[0] = (i < D + 4);
      sw[2] = (i >= 2 && i < 9);
      step(1);
      nh += int'(hop_pulse);
    end
    sw = 4'b0;
    checks++; if (nh != 1 || player_x !== 10'd304 || player_y !== 10'd384) begin
      errs++; $display("FAIL cooldown_drop got=%0d/%0d/%0d exp=1/304/384", nh, player_x, player_y); end
  endtask

  task automatic test_win();
    int nh, nw, th = 0, tw = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin tap(4'b0001, nh, nw); th += nh; tw += nw; end
    checks++; if (th != 12 || tw != 0 || player_y !== 10'd32) begin
      errs++; $display("FAIL climb got=%0d/%0d/%0d exp=12/0/32", th, tw, player_y); end
    sw = 4'b0001;
    step(D + 3);
    checks++; if (hop_pulse !== 1'b1 || player_y !== 10'd0) begin
      errs++; $display("FAIL row0 got=%b/%0d exp=1/0", hop_pulse, player_y); end
    step(1);
    checks++; if (win_pulse !== 1'b1 || player_x !== 10'd304 || player_y !== 10'd416 || lives !== 2'd3) begin
      errs++; $display("FAIL win got=%b/%0d/%0d/%0d exp=1/304/416/3", win_pulse, player_x, player_y, lives); end
    step(1);
    checks++; if (win_pulse !== 1'b0) begin errs++; $display("FAIL win_width got=%b exp=0", win_pulse); end
    sw = 4'b0;
    step(2*D + HC + 8);
  endtask

  task automatic test_collision();
    int nh, nw;
    do_reset();
    tap(4'b0001, nh, nw);
    collision = 1'b1; step(1); collision = 1'b0;
    checks++; if (lives !== 2'd2 || dead !== 1'b1 || player_y !== 10'd384) begin
      errs++; $display("FAIL die1 got=%0d/%b/%0d exp=2/1/384", lives, dead, player_y); end
    collision = 1'b1; step(1); collision = 1'b0;
    checks++; if (lives !== 2'd2) begin errs++; $display("FAIL dead_ignore got=%0d exp=2", lives); end
    tick(59);
    checks++; if (dead !== 1'b1 || player_y !== 10'd384) begin
      errs++; $display("FAIL dead_hold got=%b/%0d exp=1/384", dead, player_y); end
    tick(1);
    checks++; if (dead !== 1'b0 || player_x !== 10'd304 || player_y !== 10'd416) begin
      errs++; $display("FAIL respawn got=%b/%0d/%0d exp=0/304/416", dead, player_x, player_y); end
  endtask

  task automatic test_game_over();
    int nh = 0;
    collision = 1'b1; step(1); collision = 1'b0;
    checks++; if (lives !== 2'd1 || dead !== 1'b1) begin
      errs++; $display("FAIL die2 got=%0d/%b exp=1/1", lives, dead); end
    tick(60);
    collision = 1'b1; step(1); collision = 1'b0;
    checks++; if (lives !== 2'd0 || game_over !== 1'b1 || dead !== 1'b0) begin
      errs++; $display("FAIL over got=%0d/%b/%b exp=0/1/0", lives, game_over, dead); end
    collision = 1'b1; step(1); collision = 1'b0;
    checks++; if (lives !== 2'd0 || game_over !== 1'b1) begin
      errs++; $display("FAIL over_ignore got=%0d/%b exp=0/1", lives, game_over); end
    sw = 4'b0001;
    step(D + 2);
    checks++; if (game_over !== 1'b1) begin errs++; $display("FAIL over_early got=%b exp=1", game_over); end
    step(1);
    checks++; if (game_over !== 1'b0 || lives !== 2'd3 || hop_pulse !== 1'b0 || player_y !== 10'd416) begin
      errs++; $display("FAIL restart got=%b/%0d/%b/%0d exp=0/3/0/416", game_over, lives, hop_pulse, player_y); end
    step(1);
    sw = 4'b0;
    for (int i = 0; i < 2*D + HC + 8; i++) begin step(1); nh += int'(hop_pulse); end
    checks++; if (nh != 0) begin errs++; $display("FAIL restart_nohop got=%0d exp=0", nh); end
  endtask

  task automatic test_reset_mid();
    int nh = 0;
    do_reset();
    sw = 4'b0001;
    step(3);
    RST_N = 1'b0; step(1); RST_N = 1'b1;
    step(D + 2);
    checks++; if (hop_pulse !== 1'b0) begin errs++; $display("FAIL rst_deb_early got=%b exp=0", hop_pulse); end
    step(1);
    checks++; if (hop_pulse !== 1'b1 || player_y !== 10'd384) begin
      errs++; $display("FAIL rst_deb_hop got=%b/%0d exp=1/384", hop_pulse, player_y); end
    step(3);
    RST_N = 1'b0; sw = 4'b0; step(1); RST_N = 1'b1;
    checks++; if (player_y !== 10'd416 || hop_pulse !== 1'b0 || lives !== 2'd3) begin
      errs++; $display("FAIL rst_cd got=%0d/%b/%0d exp=416/0/3", player_y, hop_pulse, lives); end
    for (int i = 0; i < 2*D + HC + 8; i++) begin step(1); nh += int'(hop_pulse); end
    checks++; if (nh != 0) begin errs++; $display("FAIL rst_cd_quiet got=%0d exp=0", nh); end
    collision = 1'b1; step(1); collision = 1'b0;
    RST_N = 1'b0; step(1); RST_N = 1'b1;
    checks++; if (dead !== 1'b0 || lives !== 2'd3) begin
      errs++; $display("FAIL rst_dead got=%b/%0d exp=0/3", dead, lives); end
  endtask

  task automatic test_autorepeat();
    int nh = 0, exp_h;
`ifdef FROG_AUTOREPEAT_EN
    exp_h = 3;
`else
    exp_h = 1;
`endif
    do_reset();
    sw = 4'b1000;
    for (int i = 0; i < 3*HC + D + 2; i++) begin step(1); nh += int'(hop_pulse); end
    checks++; if (nh != exp_h || int'(player_x) != 304 + 32*exp_h) begin
      errs++; $display("FAIL hold_right got=%0d/%0d exp=%0d/%0d", nh, player_x, exp_h, 304 + 32*exp_h); end
    sw = 4'b0;
    step(30);
  endtask

  initial begin
    test_reset();
    test_hop_latency();
    test_glitch();
    test_bounds();
    test_back_to_back();
    test_win();
    test_collision();
    test_game_over();
    test_reset_mid();
    test_autorepeat();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
